// File: rtl/pong_game_ctrl.sv
// Pong game-state sequencer: NEWGAME/PLAY/NEWBALL/OVER FSM with ball count, BCD score and serve delay.
// Optional right-player score counter enabled by defining PONG_P2_SCORE_EN.
module pong_game_ctrl #(
    parameter int BALLS       = 3,
    parameter int TIMER_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    input  logic       hit_r,
    output logic [1:0] ball,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] text_en,
    output logic       graph_still,
    output logic [1:0] game_state
);

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_e;

    localparam logic [1:0] BALLS_INIT = 2'(BALLS);
    localparam logic [7:0] TICKS_INIT = 8'(TIMER_TICKS);

    // Two-digit BCD increment, {tens, ones}; 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    state_e     state_q, state_d;
    logic [1:0] ball_q, ball_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] score_l_q, score_l_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= NEWGAME;
            ball_q    <= BALLS_INIT;
            timer_q   <= 8'd0;
            score_l_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            ball_q    <= ball_d;
            timer_q   <= timer_d;
            score_l_q <= score_l_d;
        end
    end

    logic start_game;

    always_comb begin
        state_d    = state_q;
        ball_d     = ball_q;
        score_l_d  = score_l_q;
        start_game = 1'b0;
        timer_d    = (refr_tick && timer_q != 8'd0) ? timer_q - 8'd1 : timer_q;
        case (state_q)
            NEWGAME: begin
                if (btn != 2'b00) begin
                    state_d    = PLAY;
                    ball_d     = BALLS_INIT;
                    score_l_d  = 8'd0;
                    start_game = 1'b1;
                end
            end
            PLAY: begin
                if (hit)
                    score_l_d = bcd_inc(score_l_q);
                // A miss load overrides any coincident frame tick.
                if (miss) begin
                    ball_d  = ball_q - 2'd1;
                    timer_d = TICKS_INIT;
                    state_d = (ball_q == 2'd1) ? OVER : NEWBALL;
                end
            end
            NEWBALL: begin
                if (timer_q == 8'd0 && btn != 2'b00)
                    state_d = PLAY;
            end
            OVER: begin
                if (timer_q == 8'd0) begin
                    state_d = NEWGAME;
                    ball_d  = BALLS_INIT;
                end
            end
            default: state_d = NEWGAME;
        endcase
    end

`ifdef PONG_P2_SCORE_EN
    logic [7:0] score_r_q, score_r_d;

    always_comb begin
        score_r_d = score_r_q;
        if (start_game)
            score_r_d = 8'd0;
        else if (state_q == PLAY && hit_r)
            score_r_d = bcd_inc(score_r_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            score_r_q <= 8'd0;
        else
            score_r_q <= score_r_d;
    end

    assign dig2 = score_r_q[3:0];
    assign dig3 = score_r_q[7:4];
`else
    logic unused_p2;
    assign unused_p2 = hit_r ^ start_game;
    assign dig2      = 4'h0;
    assign dig3      = 4'h0;
`endif

    always_comb begin
        text_en     = 4'b1110;
        graph_still = 1'b1;
        case (state_q)
            NEWGAME: text_en = 4'b1110;
            PLAY: begin
                text_en     = 4'b1000;
                graph_still = 1'b0;
            end
            NEWBALL: text_en = 4'b1000;
            OVER:    text_en = 4'b1101;
            default: text_en = 4'b1110;
        endcase
    end

    assign ball       = ball_q;
    assign dig0       = score_l_q[3:0];
    assign dig1       = score_l_q[7:4];
    assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: reset, start, scoring, serve delay, game over, simultaneous events.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn;
    logic       refr_tick, hit, miss, hit_r;
    logic [1:0] ball, game_state;
    logic [3:0] dig0, dig1, dig2, dig3, text_en;
    logic       graph_still;

    int errors = 0;
    int checks = 0;

    pong_game_ctrl #(.BALLS(3), .TIMER_TICKS(120)) dut (
        .clk(clk), .reset(reset), .btn(btn), .refr_tick(refr_tick),
        .hit(hit), .miss(miss), .hit_r(hit_r), .ball(ball),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .text_en(text_en), .graph_still(graph_still), .game_state(game_state)
    );

    always #5 clk = ~clk;

    // Inputs change on negedge; the posedge between two negedges registers them.
    task automatic pulse_hit(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1; @(negedge clk); hit = 1'b0; @(negedge clk);
        end
    endtask

    task automatic pulse_hit_r(input int n);
        for (int i = 0; i < n; i++) begin
            hit_r = 1'b1; @(negedge clk); hit_r = 1'b0; @(negedge clk);
        end
    endtask

    task automatic pulse_tick(input int n);
        for (int i = 0; i < n; i++) begin
            refr_tick = 1'b1; @(negedge clk); refr_tick = 1'b0; @(negedge clk);
        end
    endtask

    task automatic pulse_miss();
        miss = 1'b1; @(negedge clk); miss = 1'b0;
    endtask

    task automatic press_start();
        btn = 2'b01; @(negedge clk); btn = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", game_state); end
        checks++; if (ball !== 2'd3) begin errors++; $display("FAIL reset_ball: got %0d want 3", ball); end
        checks++; if ({dig3, dig2, dig1, dig0} !== 16'h0) begin errors++; $display("FAIL reset_digits: got %h want 0000", {dig3, dig2, dig1, dig0}); end
        checks++; if (text_en !== 4'b1110) begin errors++; $display("FAIL reset_text_en: got %b want 1110", text_en); end
        checks++; if (graph_still !== 1'b1) begin errors++; $display("FAIL reset_graph_still: got %b want 1", graph_still); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL idle_no_btn: got %b want 00", game_state); end
    endtask

    task automatic test_start();
        press_start();
        checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL start_state: got %b want 01", game_state); end
        checks++; if (graph_still !== 1'b0) begin errors++; $display("FAIL start_graph_still: got %b want 0", graph_still); end
        checks++; if (text_en !== 4'b1000) begin errors++; $display("FAIL start_text_en: got %b want 1000", text_en); end
        checks++; if (ball !== 2'd3) begin errors++; $display("FAIL start_ball: got %0d want 3", ball); end
    endtask

    task automatic test_score();
        pulse_hit(12);
        checks++; if ({dig1, dig0} !== 8'h12) begin errors++; $display("FAIL score_12: got %h want 12", {dig1, dig0}); end
        pulse_hit(87);
        checks++; if ({dig1, dig0} !== 8'h99) begin errors++; $display("FAIL score_99: got %h want 99", {dig1, dig0}); end
        pulse_hit(1);
        checks++; if ({dig1, dig0} !== 8'h00) begin errors++; $display("FAIL score_wrap: got %h want 00", {dig1, dig0}); end
    endtask

    task automatic test_reset_midplay();
        pulse_hit(7);
        checks++; if ({dig1, dig0} !== 8'h07) begin errors++; $display("FAIL pre_reset_score: got %h want 07", {dig1, dig0}); end
        #2 reset = 1'b1;
        #1;
        checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL async_reset_state: got %b want 00", game_state); end
        checks++; if (ball !== 2'd3) begin errors++; $display("FAIL async_reset_ball: got %0d want 3", ball); end
        checks++; if ({dig1, dig0} !== 8'h00) begin errors++; $display("FAIL async_reset_score: got %h want 00", {dig1, dig0}); end
        checks++; if (text_en !== 4'b1110 || graph_still !== 1'b1) begin errors++; $display("FAIL async_reset_outputs: got %b/%b want 1110/1", text_en, graph_still); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        press_start();
    endtask

    task automatic test_miss_delay();
        pulse_miss();
        checks++; if (game_state !== 2'b10) begin errors++; $display("FAIL miss_state: got %b want 10", game_state); end
        checks++; if (ball !== 2'd2) begin errors++; $display("FAIL miss_ball: got %0d want 2", ball); end
        checks++; if (text_en !== 4'b1000 || graph_still !== 1'b1) begin errors++; $display("FAIL newball_outputs: got %b/%b want 1000/1", text_en, graph_still); end
        btn = 2'b10;
        pulse_hit(3);
        checks++; if ({dig1, dig0} !== 8'h00) begin errors++; $display("FAIL hit_in_newball: got %h want 00", {dig1, dig0}); end
        pulse_tick(119);
        checks++; if (game_state !== 2'b10) begin errors++; $display("FAIL serve_early: got %b want 10", game_state); end
        pulse_tick(1);
        checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL serve_after_delay: got %b want 01", game_state); end
        btn = 2'b00;
    endtask

    task automatic test_simultaneous();
        pulse_hit(5);
        checks++; if ({dig1, dig0} !== 8'h05) begin errors++; $display("FAIL pre_sim_score: got %h want 05", {dig1, dig0}); end
        hit = 1'b1; miss = 1'b1; refr_tick = 1'b1;
        @(negedge clk);
        hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
        checks++; if ({dig1, dig0} !== 8'h06) begin errors++; $display("FAIL sim_score: got %h want 06", {dig1, dig0}); end
        checks++; if (game_state !== 2'b10 || ball !== 2'd1) begin errors++; $display("FAIL sim_state_ball: got %b/%0d want 10/1", game_state, ball); end
        btn = 2'b11;
        pulse_tick(119);
        checks++; if (game_state !== 2'b10) begin errors++; $display("FAIL sim_timer_load: got %b want 10", game_state); end
        pulse_tick(1);
        checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL sim_serve: got %b want 01", game_state); end
        btn = 2'b00;
    endtask

    task automatic test_game_over();
        pulse_miss();
        checks++; if (game_state !== 2'b11 || ball !== 2'd0) begin errors++; $display("FAIL over_state_ball: got %b/%0d want 11/0", game_state, ball); end
        checks++; if (text_en !== 4'b1101 || graph_still !== 1'b1) begin errors++; $display("FAIL over_outputs: got %b/%b want 1101/1", text_en, graph_still); end
        pulse_hit(2);
        pulse_tick(119);
        checks++; if (game_state !== 2'b11) begin errors++; $display("FAIL over_early: got %b want 11", game_state); end
        pulse_tick(1);
        checks++; if (game_state !== 2'b00 || ball !== 2'd3) begin errors++; $display("FAIL over_to_newgame: got %b/%0d want 00/3", game_state, ball); end
        checks++; if ({dig1, dig0} !== 8'h06) begin errors++; $display("FAIL score_retained: got %h want 06", {dig1, dig0}); end
        checks++; if (text_en !== 4'b1110) begin errors++; $display("FAIL newgame_text_en: got %b want 1110", text_en); end
    endtask

    task automatic test_p2_score();
        logic [3:0] exp_dig2;
`ifdef PONG_P2_SCORE_EN
        exp_dig2 = 4'd3;
`else
        exp_dig2 = 4'd0;
`endif
        press_start();
        checks++; if ({dig1, dig0} !== 8'h00) begin errors++; $display("FAIL restart_clear: got %h want 00", {dig1, dig0}); end
        pulse_hit_r(3);
        checks++; if (dig2 !== exp_dig2 || dig3 !== 4'd0) begin errors++; $display("FAIL p2_score: got %h%h want 0%h", dig3, dig2, exp_dig2); end
        checks++; if ({dig1, dig0} !== 8'h00) begin errors++; $display("FAIL hit_r_left_score: got %h want 00", {dig1, dig0}); end
    endtask

    initial begin
        reset = 1'b1; btn = 2'b00; refr_tick = 1'b0;
        hit = 1'b0; miss = 1'b0; hit_r = 1'b0;
        test_reset();
        test_start();
        test_score();
        test_reset_midplay();
        test_miss_delay();
        test_simultaneous();
        test_game_over();
        test_p2_score();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
